// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: one-cycle request strobe out, single-pulse response back.
interface instr_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr, input rvalid, input rdata);
    modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, keeps one imem read outstanding and presents inst/pc to decode.
// Optional IFETCH_MISALIGN_EN: a misaligned redirect raises a sticky error and halts fetch until reset.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall_i,
    input  logic          redirect_i,
    input  logic [31:0]   redirect_pc_i,
    instr_fetch_if.master imem,
    output logic [31:0]   inst_o,
    output logic [31:0]   pc_o,
    output logic [31:0]   pc_plus4_o,
    output logic          inst_valid_o,
    output logic          misalign_err_o
);
    typedef enum logic [1:0] {
        ST_ISSUE   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_PRESENT = 2'd2,
        ST_HALT    = 2'd3
    } state_e;

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'd3;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;
    logic        kill_q, kill_d;
    logic        req;
    logic [31:0] redirect_tgt;
    logic        redirect_bad;

    assign redirect_tgt = redirect_pc_i & ~32'd3;

`ifdef IFETCH_MISALIGN_EN
    logic err_q;

    assign redirect_bad   = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign misalign_err_o = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (redirect_bad && state_q != ST_HALT) begin
            err_q <= 1'b1;
        end
    end
`else
    assign redirect_bad   = 1'b0;
    assign misalign_err_o = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path through the case infers a latch.
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        valid_d    = valid_q;
        kill_d     = kill_q;
        req        = 1'b0;

        case (state_q)
            ST_ISSUE: begin
                if (!redirect_i) begin
                    req     = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem.rvalid) begin
                    if (kill_q || redirect_i) begin
                        // Stale or superseded response: drop it and refetch from fetch_pc.
                        kill_d  = 1'b0;
                        state_d = ST_ISSUE;
                    end else begin
                        inst_d     = imem.rdata;
                        pc_d       = fetch_pc_q;
                        valid_d    = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = ST_PRESENT;
                    end
                end
            end
            ST_PRESENT: begin
                if (!redirect_i && !stall_i) begin
                    valid_d = 1'b0;
                    req     = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            default: begin
            end
        endcase

        // Redirect overrides stall and consumption; HALT ignores everything until reset.
        if (redirect_i && state_q != ST_HALT) begin
            fetch_pc_d = redirect_tgt;
            valid_d    = 1'b0;
            if (state_q != ST_WAIT) begin
                state_d = ST_ISSUE;
            end else if (!imem.rvalid) begin
                kill_d = 1'b1;
            end
            if (redirect_bad) begin
                state_d = ST_HALT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ISSUE;
            fetch_pc_q <= RESET_PC_ALIGNED;
            pc_q       <= RESET_PC_ALIGNED;
            inst_q     <= NOP_INST;
            valid_q    <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            valid_q    <= valid_d;
            kill_q     <= kill_d;
        end
    end

    // The strobe is gated by reset because the reset state is ISSUE.
    assign imem.req     = req && rst_n;
    assign imem.addr    = fetch_pc_q;
    assign inst_o       = valid_q ? inst_q : NOP_INST;
    assign pc_o         = pc_q;
    assign pc_plus4_o   = pc_q + 32'd4;
    assign inst_valid_o = valid_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand-written corner sequences and a random run
// checked against an instruction-stream scoreboard with a variable-latency memory model.
module tb_instr_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] inst, pc, pc_plus4;
    logic        inst_valid, misalign_err;

    instr_fetch_if imem_if();

    instr_fetch #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem          (imem_if),
        .inst_o        (inst),
        .pc_o          (pc),
        .pc_plus4_o    (pc_plus4),
        .inst_valid_o  (inst_valid),
        .misalign_err_o(misalign_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    int          checks, errors, cyc;
    bit          mem_busy, rsp_now, obs_req;
    int          mem_cnt, mem_lat;
    logic [31:0] mem_addr, obs_addr;

    // Scoreboard state for the random run.
    logic [31:0] exp_pc, prev_pc, prev_inst, redir_target;
    bit          prev_valid, prev_stall, prev_redir, redir_active;
    int          redir_due, n_present;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h5A00_0013);
    endfunction

    function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                                input logic rq, input logic [31:0] ad, input logic v,
                                input logic [31:0] p);
        vec_t r;
        r.stall = st; r.redir = rd; r.rpc = rpc;
        r.req = rq; r.addr = ad; r.valid = v; r.pc = p;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs and memory response at negedge, sample outputs 1ns later.
    task automatic step(input logic st, input logic rd, input logic [31:0] rp);
        @(negedge clk);
        cyc++;
        stall       = st;
        redirect    = rd;
        redirect_pc = rp;
        rsp_now     = 1'b0;
        if (mem_busy && mem_cnt == 1) begin
            imem_if.rvalid = 1'b1;
            imem_if.rdata  = mem_word(mem_addr);
            mem_busy       = 1'b0;
            rsp_now        = 1'b1;
        end else begin
            imem_if.rvalid = 1'b0;
            imem_if.rdata  = $urandom;
            if (mem_busy) mem_cnt--;
        end
        #1;
        obs_req  = imem_if.req;
        obs_addr = imem_if.addr;
        if (obs_req) begin
            check("one_outstanding", {31'b0, mem_busy}, 32'd0);
            mem_busy = 1'b1;
            mem_cnt  = mem_lat;
            mem_addr = obs_addr;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        imem_if.rvalid = 1'b0;
        mem_busy       = 1'b0;
        #1;
        check("rst.req", {31'b0, imem_if.req}, 32'd0);
        check("rst.valid", {31'b0, inst_valid}, 32'd0);
        check("rst.inst", inst, NOP);
        check("rst.pc", pc, 32'h0);
        check("rst.pc_plus4", pc_plus4, 32'h4);
        check("rst.misalign", {31'b0, misalign_err}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc   = -1;
    endtask

    task automatic model_step(input logic st, input logic rd, input logic [31:0] rp);
        check("pc_plus4", pc_plus4, pc + 32'd4);
        if (!inst_valid) check("nop_when_invalid", inst, NOP);
        if (obs_req) check("addr_aligned", {30'b0, obs_addr[1:0]}, 32'd0);
        if (rd) check("no_req_on_redirect", {31'b0, obs_req}, 32'd0);
`ifndef IFETCH_MISALIGN_EN
        check("misalign_tied", {31'b0, misalign_err}, 32'd0);
`endif
        if (prev_redir) check("redirect_clears_valid", {31'b0, inst_valid}, 32'd0);
        if (inst_valid && prev_valid) begin
            check("hold_legal", {30'b0, prev_stall, prev_redir}, 32'd2);
            check("hold_pc", pc, prev_pc);
            check("hold_inst", inst, prev_inst);
        end else if (inst_valid) begin
            check("stream_pc", pc, exp_pc);
            check("stream_inst", inst, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_present++;
        end else if (prev_valid && prev_stall && !prev_redir) begin
            check("stall_holds_valid", {31'b0, inst_valid}, 32'd1);
        end

        if (rd) begin
            exp_pc       = rp & ~32'd3;
            redir_active = 1'b1;
            redir_target = rp & ~32'd3;
            redir_due    = (rsp_now || !mem_busy) ? cyc + 1 : -1;
        end else if (redir_active) begin
            if (redir_due < 0 && rsp_now) redir_due = cyc + 1;
            if (obs_req) begin
                check("redirect_addr", obs_addr, redir_target);
                check("redirect_latency", cyc, redir_due);
                redir_active = 1'b0;
            end else if (redir_due >= 0 && cyc >= redir_due) begin
                check("redirect_req_missing", {31'b0, obs_req}, 32'd1);
                redir_active = 1'b0;
            end
        end
        prev_valid = inst_valid;
        prev_pc    = pc;
        prev_inst  = inst;
        prev_stall = st;
        prev_redir = rd;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[15];
        logic        st, rd;
        logic [31:0] rp;

        checks = 0; errors = 0; cyc = 0;
        rst_n = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_if.rvalid = 1'b0; imem_if.rdata = 32'h0;
        mem_busy = 1'b0; mem_cnt = 0; mem_lat = 1; mem_addr = 32'h0;

        // Straight-line fetch, a 3-cycle stall at pc=8, then redirect+stall in PRESENT.
        vecs[0]  = mk(0, 0, 32'h0,  1, 32'h0,  0, 32'h0);
        vecs[1]  = mk(0, 0, 32'h0,  0, 32'h0,  0, 32'h0);
        vecs[2]  = mk(0, 0, 32'h0,  1, 32'h4,  1, 32'h0);
        vecs[3]  = mk(0, 0, 32'h0,  0, 32'h0,  0, 32'h0);
        vecs[4]  = mk(0, 0, 32'h0,  1, 32'h8,  1, 32'h4);
        vecs[5]  = mk(0, 0, 32'h0,  0, 32'h0,  0, 32'h0);
        vecs[6]  = mk(1, 0, 32'h0,  0, 32'h0,  1, 32'h8);
        vecs[7]  = mk(1, 0, 32'h0,  0, 32'h0,  1, 32'h8);
        vecs[8]  = mk(1, 0, 32'h0,  0, 32'h0,  1, 32'h8);
        vecs[9]  = mk(0, 0, 32'h0,  1, 32'hC,  1, 32'h8);
        vecs[10] = mk(0, 0, 32'h0,  0, 32'h0,  0, 32'h0);
        vecs[11] = mk(1, 1, 32'h40, 0, 32'h0,  1, 32'hC);
        vecs[12] = mk(0, 0, 32'h0,  1, 32'h40, 0, 32'h0);
        vecs[13] = mk(0, 0, 32'h0,  0, 32'h0,  0, 32'h0);
        vecs[14] = mk(0, 0, 32'h0,  1, 32'h44, 1, 32'h40);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].stall, vecs[i].redir, vecs[i].rpc);
            check($sformatf("vec%0d.req", i), {31'b0, obs_req}, {31'b0, vecs[i].req});
            if (vecs[i].req) check($sformatf("vec%0d.addr", i), obs_addr, vecs[i].addr);
            check($sformatf("vec%0d.valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].valid});
            if (vecs[i].valid) begin
                check($sformatf("vec%0d.pc", i), pc, vecs[i].pc);
                check($sformatf("vec%0d.inst", i), inst, mem_word(vecs[i].pc));
            end else begin
                check($sformatf("vec%0d.nop", i), inst, NOP);
            end
            check($sformatf("vec%0d.pc_plus4", i), pc_plus4, pc + 32'd4);
        end

        // Redirect to 0x100 while a 3-cycle fetch of 0x10 is outstanding; reset lands mid-operation.
        do_reset();
        mem_lat = 3;
        for (int c = 0; c < 10; c++) begin
            step(1'b0, (c == 0) || (c == 2), (c == 0) ? 32'h10 : 32'h100);
            check($sformatf("kill%0d.req", c), {31'b0, obs_req}, {31'b0, (c == 1) || (c == 5) || (c == 9)});
            if (c == 1) check("kill.addr_first", obs_addr, 32'h10);
            if (c == 5) check("kill.addr_redirect", obs_addr, 32'h100);
            if (c == 9) check("kill.addr_next", obs_addr, 32'h104);
            check($sformatf("kill%0d.valid", c), {31'b0, inst_valid}, {31'b0, c == 9});
            if (c == 9) begin
                check("kill.pc", pc, 32'h100);
                check("kill.inst", inst, mem_word(32'h100));
            end
        end

        // PC wrap at the top of the address space.
        do_reset();
        mem_lat = 1;
        for (int c = 0; c < 4; c++) begin
            step(1'b0, c == 0, 32'hFFFF_FFFC);
            if (c == 1) check("wrap.req_addr", obs_addr, 32'hFFFF_FFFC);
            if (c == 3) begin
                check("wrap.valid", {31'b0, inst_valid}, 32'd1);
                check("wrap.pc", pc, 32'hFFFF_FFFC);
                check("wrap.pc_plus4", pc_plus4, 32'h0);
                check("wrap.inst", inst, mem_word(32'hFFFF_FFFC));
                check("wrap.next_addr", obs_addr, 32'h0);
            end
        end

        // Misaligned redirect target.
        do_reset();
`ifdef IFETCH_MISALIGN_EN
        for (int c = 0; c < 6; c++) begin
            step(1'b0, c == 0, 32'h102);
            check($sformatf("halt%0d.req", c), {31'b0, obs_req}, 32'd0);
            check($sformatf("halt%0d.valid", c), {31'b0, inst_valid}, 32'd0);
            check($sformatf("halt%0d.err", c), {31'b0, misalign_err}, {31'b0, c > 0});
        end
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        check("halt.restart_req", {31'b0, obs_req}, 32'd1);
        check("halt.restart_addr", obs_addr, 32'h0);
`else
        for (int c = 0; c < 4; c++) begin
            step(1'b0, c == 0, 32'h102);
            check($sformatf("mis%0d.req", c), {31'b0, obs_req}, {31'b0, (c == 1) || (c == 3)});
            check($sformatf("mis%0d.err", c), {31'b0, misalign_err}, 32'd0);
            if (c == 1) check("mis.addr", obs_addr, 32'h100);
            if (c == 3) begin
                check("mis.pc", pc, 32'h100);
                check("mis.valid", {31'b0, inst_valid}, 32'd1);
            end
        end
`endif

        // Random stalls, redirects and memory latency against the stream scoreboard.
        do_reset();
        exp_pc = 32'h0; prev_valid = 1'b0; prev_stall = 1'b0; prev_redir = 1'b0;
        prev_pc = 32'h0; prev_inst = NOP; redir_active = 1'b0; redir_due = -1; n_present = 0;
        for (int n = 0; n < 4000; n++) begin
            st = ($urandom_range(0, 9) < 3);
            rd = ($urandom_range(0, 19) == 0);
            rp = $urandom;
`ifdef IFETCH_MISALIGN_EN
            rp = rp & ~32'd3;
`endif
            mem_lat = $urandom_range(1, 4);
            step(st, rd, rp);
            model_step(st, rd, rp);
        end
        check("progress", {31'b0, n_present > 100}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of the instruction decoder/controller. It owns the program counter and issues one word-aligned read at a time to instruction memory. It registers the returned word and presents `inst`/`pc` with a valid flag to decode. It accepts a redirect (taken branch, `jal`, `jalr`) from execute and a stall from downstream. When no instruction is valid, it drives a canonical NOP so decode control outputs stay benign.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `NOP_INST`, default 32'h0000_0013: word driven on `inst` whenever `inst_valid`=0 (`addi x0,x0,0`).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `stall`  in  1  decode cannot accept; hold the presented instruction.
- `redirect`  in  1  one-cycle pulse; next fetch comes from `redirect_pc`.
- `redirect_pc`  in  32  target of the redirect.
- `imem_req`  out  1  one-cycle read strobe.
- `imem_addr`  out  32  read address, word-aligned; valid while `imem_req`=1.
- `imem_rvalid`  in  1  read data valid; exactly one pulse per request; ≥1 cycle after `imem_req`.
- `imem_rdata`  in  32  instruction word; sampled when `imem_rvalid`=1.
- `inst`  out  32  instruction to decode (`NOP_INST` when not valid).
- `pc`  out  32  address of `inst`.
- `pc_plus4`  out  32  `pc`+4, modulo 2^32.
- `inst_valid`  out  1  `inst`/`pc` hold a live instruction.
- `misalign_err`  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- Registers: `fetch_pc` (address of the outstanding or next request), `pc`, `inst`, `inst_valid`, `kill` (the outstanding response is stale), and a 2-bit state.
- States:
  - **ISSUE**: assert `imem_req` with `imem_addr`=`fetch_pc`, then go to WAIT.
  - **WAIT**: wait for `imem_rvalid`.
  - **PRESENT**: hold `inst_valid`=1.
  - **HALT**: only reachable with the macro enabled.
- WAIT, `imem_rvalid`=1, `kill`=0: capture `inst`←`imem_rdata`, `pc`←`fetch_pc`, `inst_valid`←1, `fetch_pc`←`fetch_pc`+4, go to PRESENT.
- WAIT, `imem_rvalid`=1, `kill`=1: discard the data, clear `kill`, go to ISSUE (`fetch_pc` already holds the redirect target).
- PRESENT, `stall`=0: the instruction is consumed at this edge. Clear `inst_valid`, assert `imem_req` for `fetch_pc` combinationally in this same cycle, go to WAIT.
- PRESENT, `stall`=1: hold all outputs; no request is issued.
- Redirect has priority over stall and over consumption:
  - In every state, `fetch_pc`←`redirect_pc` and `inst_valid`←0 at the edge.
  - In WAIT (with no `imem_rvalid` in the same cycle), set `kill`←1.
  - WAIT with `imem_rvalid` in the same cycle: discard the data, do not set `kill`, go to ISSUE.
  - ISSUE or PRESENT: suppress `imem_req` in that cycle and go to ISSUE.
  - A redirect in the same cycle as an `imem_req` that was already issued leaves the response stale, so `kill` is set.
- At most one request is outstanding at any time.
- `imem_addr[1:0]` is always 2'b00. PC arithmetic wraps modulo 2^32: `pc`=32'hFFFF_FFFC gives `pc_plus4`=0.

## Timing
- Reset (asynchronous assert): state=ISSUE, `fetch_pc`=`RESET_PC`, `pc`=`RESET_PC`, `inst`=`NOP_INST`, `inst_valid`=0, `kill`=0, `misalign_err`=0, `imem_req`=0 while `rst_n`=0.
- First `imem_req` occurs in the first cycle after reset deassertion.
- Latency from `imem_rvalid` to `inst_valid`=1 is one cycle (registered).
- With a 1-cycle memory and no stalls, throughput is one instruction per 2 cycles.
- A redirect asserted in cycle N produces `imem_req` at `redirect_pc`:
  - in cycle N+1 if no response is outstanding;
  - otherwise in the cycle after the stale `imem_rvalid`.
- Reset mid-operation abandons any outstanding request. An `imem_rvalid` arriving after reset deassertion while in ISSUE is ignored.

## Configuration
- `IFETCH_MISALIGN_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 sets `misalign_err`=1 (sticky until reset) and sends the FSM to HALT.
  - HALT drives `inst_valid`=0 and issues no requests, until reset.
  - A stale response that is still outstanding is absorbed silently.
- `IFETCH_MISALIGN_EN` undefined: `redirect_pc[1:0]` is forced to 0, `misalign_err` is tied to 0, and HALT does not exist.

## Test plan
- Reset with `RESET_PC`=0, 1-cycle memory returning `addi x1,x0,5` (32'h0050_0093) → `imem_req` at addr 0 in the first cycle after reset; `inst_valid`=1, `inst`=32'h0050_0093, `pc`=0, `pc_plus4`=4 two cycles later.
- Straight-line fetch, no stalls → `imem_addr` sequence 0,4,8,C with one request every 2 cycles; `inst_valid` alternates 1/0.
- `stall`=1 for 3 cycles in PRESENT at `pc`=8 → `inst`/`pc` stable, no `imem_req`; the request for 0xC is issued in the cycle `stall` falls.
- Redirect to 0x100 while a 3-cycle-latency fetch of 0x10 is outstanding → the 0x10 data is discarded and `inst_valid` stays 0; the next request is at 0x100, and `pc`=0x100 is presented.
- Redirect and `stall` both high in PRESENT → the redirect wins: `inst_valid`=0 next cycle, `imem_req` at `redirect_pc`.
- Redirect to 0x102: with `IFETCH_MISALIGN_EN`, `misalign_err`=1, fetch halts and stays halted until `rst_n` pulses low. Without the macro, the fetch goes to 0x100.
